mem_stage_sram_ctrl: RTL

- Memory stage of the 5-stage ARM-subset pipeline, directly downstream of the EXE/MEM pipeline register.
- Consumes the registered control signals, ALU result (address), Rm value (store data) and destination from that register.
- Performs each 32-bit load/store as two 16-bit accesses to the external SRAM, stalling the pipeline with `freeze` while the access runs.
- Presents load data and pass-through fields to the MEM/WB register.

---
 rtl/mem_stage_sram_ctrl_if.sv | 26 ++
 rtl/mem_stage_sram_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mem_stage_sram_ctrl_if.sv
// rtl/mem_stage_sram_ctrl_if.sv - EXE/MEM request and MEM/WB result bundle for the memory stage
interface mem_stage_sram_ctrl_if;
  logic        mem_r_en_in;
  logic        mem_w_en_in;
  logic        wb_en_in;
  logic [31:0] alu_res_in;
  logic [31:0] val_rm_in;
  logic [3:0]  dest_in;
  logic        wb_en_out;
  logic        mem_r_en_out;
  logic [31:0] alu_res_out;
  logic [3:0]  dest_out;
  logic [31:0] mem_data_out;
  logic        freeze;
  logic        mem_err;

  modport master (
    output mem_r_en_in, mem_w_en_in, wb_en_in, alu_res_in, val_rm_in, dest_in,
    input  wb_en_out, mem_r_en_out, alu_res_out, dest_out, mem_data_out, freeze, mem_err
  );

  modport slave (
    input  mem_r_en_in, mem_w_en_in, wb_en_in, alu_res_in, val_rm_in, dest_in,
    output wb_en_out, mem_r_en_out, alu_res_out, dest_out, mem_data_out, freeze, mem_err
  );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// rtl/mem_stage_sram_ctrl.sv - pipeline memory stage doing 32-bit accesses as two 16-bit SRAM halves
// Optional request bounds checking is compiled in with MEM_BOUNDS_CHECK_EN.
module mem_stage_sram_ctrl #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 1,
  parameter int SRAM_AW     = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_stage_sram_ctrl_if.slave pipe,
  output logic [SRAM_AW-1:0]   sram_addr,
  output logic                 sram_we_n,
  inout  wire  [15:0]          sram_dq
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t             state;
  state_t             state_nx;
  logic [2:0]         wait_cnt;
  logic [15:0]        lo_q;
  logic [31:0]        mem_data_q;
  logic [31:0]        offset;
  logic [SRAM_AW-2:0] word;
  logic               req;
  logic               is_store;
  logic               is_load;
  logic               reject;
  logic               half_done;
  logic               freeze_c;
  logic               drive_en;
  logic [15:0]        drive_data;
  logic               unused_offset_bits;

  assign pipe.wb_en_out    = pipe.wb_en_in;
  assign pipe.mem_r_en_out = pipe.mem_r_en_in;
  assign pipe.alu_res_out  = pipe.alu_res_in;
  assign pipe.dest_out     = pipe.dest_in;
  assign pipe.mem_data_out = mem_data_q;
  assign pipe.freeze       = freeze_c;

  assign offset    = pipe.alu_res_in - 32'(BASE_ADDR);
  assign word      = offset[SRAM_AW:2];
  assign req       = pipe.mem_r_en_in | pipe.mem_w_en_in;
  assign is_store  = pipe.mem_w_en_in;
  assign is_load   = pipe.mem_r_en_in & ~pipe.mem_w_en_in;
  assign half_done = (wait_cnt == 3'(WAIT_CYCLES));

  assign unused_offset_bits = ^{offset[1:0], offset[31:SRAM_AW+1]};

`ifdef MEM_BOUNDS_CHECK_EN
  logic err_q;

  // word >= 2^(SRAM_AW-1) is the same as any offset bit above SRAM_AW being set
  assign reject = (pipe.alu_res_in < 32'(BASE_ADDR)) ||
                  (pipe.alu_res_in[1:0] != 2'b00) ||
                  ((offset >> (SRAM_AW + 1)) != 32'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state == IDLE && req && reject) begin
      err_q <= 1'b1;
    end
  end

  assign pipe.mem_err = err_q;
`else
  assign reject       = 1'b0;
  assign pipe.mem_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    freeze_c   = 1'b0;
    sram_addr  = '0;
    sram_we_n  = 1'b1;
    drive_en   = 1'b0;
    drive_data = 16'h0000;
    case (state)
      IDLE: begin
        if (req && !reject) begin
          state_nx = LO;
          freeze_c = 1'b1;
        end
      end
      LO: begin
        freeze_c   = 1'b1;
        sram_addr  = {word, 1'b0};
        sram_we_n  = ~is_store;
        drive_en   = is_store;
        drive_data = pipe.val_rm_in[15:0];
        if (half_done) state_nx = HI;
      end
      HI: begin
        freeze_c   = 1'b1;
        sram_addr  = {word, 1'b1};
        sram_we_n  = ~is_store;
        drive_en   = is_store;
        drive_data = pipe.val_rm_in[31:16];
        if (half_done) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    // a held request must not keep the pipeline stalled while reset is asserted
    if (rst) freeze_c = 1'b0;
  end

  assign sram_dq = drive_en ? drive_data : 16'hzzzz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt   <= 3'd0;
      lo_q       <= 16'h0000;
      mem_data_q <= 32'h0000_0000;
    end else begin
      case (state)
        LO: begin
          if (half_done) begin
            wait_cnt <= 3'd0;
            if (is_load) lo_q <= sram_dq;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        HI: begin
          if (half_done) begin
            wait_cnt <= 3'd0;
            if (is_load) mem_data_q <= {sram_dq, lo_q};
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        default: begin
          wait_cnt <= 3'd0;
        end
      endcase
    end
  end

endmodule
